// File: rtl/tnn_pkg.sv
// Shared types and helpers for the spike-time (TNN) interface blocks.
package tnn_pkg;

    localparam int unsigned TIME_W_DEF = 3;

    typedef logic [TIME_W_DEF-1:0] spike_time_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        REST = 2'd2
    } enc_state_e;

    // All-ones code of width w marks a channel that does not spike this gamma.
    function automatic logic [31:0] no_spike(input int unsigned w);
        return (32'd1 << w) - 32'd1;
    endfunction

endpackage

// File: rtl/counter.sv
// Clearable up-counter primitive; also exposes the value it will hold next cycle.
module counter #(
    parameter int unsigned WIDTH = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             en,
    output logic [WIDTH-1:0] count,
    output logic [WIDTH-1:0] count_nxt_c
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    // Next count: clear wins over increment.
    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (en) begin
            count_d = count_q + WIDTH'(1);
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count       = count_q;
    assign count_nxt_c = count_d;

endmodule

// File: rtl/spike_lane.sv
// One spike line: latches its spike time and produces a sticky-low, idle-high edge.
module spike_lane
    import tnn_pkg::*;
#(
    parameter int unsigned TIME_W = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,     // accept a new time, start a fresh gamma
    input  logic              clr,      // force line idle-high
    input  logic              run,      // advance within the current gamma
    input  logic [TIME_W-1:0] in_time,
    input  logic [TIME_W-1:0] t_now,    // run index the line is being computed for
    output logic              spike
);

    localparam logic [TIME_W-1:0] NO_SPIKE = TIME_W'(no_spike(TIME_W));

    logic [TIME_W-1:0] time_q;
    logic [TIME_W-1:0] time_d;
    logic              spike_q;
    logic              spike_d;
    logic              fire_load;
    logic              fire_run;

    assign fire_load = (in_time != NO_SPIKE) && (in_time <= t_now);
    assign fire_run  = (time_q  != NO_SPIKE) && (time_q  <= t_now);

    // Line update: once low it stays low until cleared or reloaded.
    always_comb begin
        time_d  = time_q;
        spike_d = spike_q;
        if (clr) begin
            spike_d = 1'b1;
        end else if (load) begin
            time_d  = in_time;
            spike_d = ~fire_load;
        end else if (run) begin
            spike_d = spike_q & ~fire_run;
        end
    end

    // Latched time and line state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            time_q  <= '0;
            spike_q <= 1'b1;
        end else begin
            time_q  <= time_d;
            spike_q <= spike_d;
        end
    end

    assign spike = spike_q;

endmodule

// File: rtl/spike_time_encoder.sv
// Replays a frame of binary spike times as falling edges over one gamma cycle.
module spike_time_encoder
    import tnn_pkg::*;
#(
    parameter int unsigned NUM_CH   = 8,
    parameter int unsigned TIME_W   = 3,
    parameter int unsigned REST_CYC = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [NUM_CH*TIME_W-1:0] in_times,
    input  logic                     flush,
    output logic [NUM_CH-1:0]        spike,
    output logic                     gamma_start,
    output logic                     gamma_clear,
    output logic                     busy,
    output logic [TIME_W-1:0]        t_now
);

    localparam int unsigned T_LAST = (1 << TIME_W) - 1;
    localparam int unsigned REST_W = (REST_CYC > 1) ? $clog2(REST_CYC) : 1;

    enc_state_e        state_q;
    enc_state_e        state_d;
    logic [REST_W-1:0] rest_q;
    logic [REST_W-1:0] rest_d;
    logic              gamma_start_q;
    logic              gamma_start_d;
    logic              gamma_clear_q;
    logic              gamma_clear_d;
    logic              busy_q;
    logic              busy_d;

    logic              run_clr;
    logic              run_en;
    logic              lane_load;
    logic              lane_clr;
    logic              lane_run;
    logic              last_rest;
    logic              accept;
    logic [TIME_W-1:0] t_cur;
    logic [TIME_W-1:0] t_nxt;

    // Ready only from state/counter registers; flush masks it for that cycle.
    assign last_rest = (state_q == REST) && (rest_q == '0);
    assign in_ready  = ((state_q == IDLE) || last_rest) && !flush;
    assign accept    = in_valid && in_ready;

    // Next-state, framing outputs and datapath controls.
    always_comb begin
        state_d       = state_q;
        rest_d        = rest_q;
        gamma_start_d = 1'b0;
        gamma_clear_d = 1'b0;
        busy_d        = busy_q;
        run_clr       = 1'b0;
        run_en        = 1'b0;
        lane_load     = 1'b0;
        lane_clr      = 1'b0;
        lane_run      = 1'b0;
        if (flush) begin
            state_d  = IDLE;
            rest_d   = '0;
            busy_d   = 1'b0;
            run_clr  = 1'b1;
            lane_clr = 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    busy_d  = 1'b0;
                    run_clr = 1'b1;
                    if (accept) begin
                        state_d       = RUN;
                        gamma_start_d = 1'b1;
                        busy_d        = 1'b1;
                        lane_load     = 1'b1;
                    end
                end
                RUN: begin
                    busy_d = 1'b1;
                    if (t_cur == TIME_W'(T_LAST)) begin
                        state_d       = REST;
                        rest_d        = REST_W'(REST_CYC - 1);
                        gamma_clear_d = 1'b1;
                        run_clr       = 1'b1;
                        lane_clr      = 1'b1;
                    end else begin
                        run_en   = 1'b1;
                        lane_run = 1'b1;
                    end
                end
                REST: begin
                    run_clr = 1'b1;
                    if (last_rest) begin
                        if (accept) begin
                            state_d       = RUN;
                            gamma_start_d = 1'b1;
                            busy_d        = 1'b1;
                            lane_load     = 1'b1;
                        end else begin
                            state_d  = IDLE;
                            busy_d   = 1'b0;
                            lane_clr = 1'b1;
                        end
                    end else begin
                        rest_d        = rest_q - REST_W'(1);
                        gamma_clear_d = 1'b1;
                        busy_d        = 1'b1;
                    end
                end
                default: begin
                    state_d  = IDLE;
                    busy_d   = 1'b0;
                    run_clr  = 1'b1;
                    lane_clr = 1'b1;
                end
            endcase
        end
    end

    // State and framing registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            rest_q        <= '0;
            gamma_start_q <= 1'b0;
            gamma_clear_q <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            rest_q        <= rest_d;
            gamma_start_q <= gamma_start_d;
            gamma_clear_q <= gamma_clear_d;
            busy_q        <= busy_d;
        end
    end

    // Run-time index t; lanes are fed the value t takes next cycle.
    counter #(
        .WIDTH(TIME_W)
    ) u_run_cnt (
        .clk         (clk),
        .rst_n       (rst_n),
        .clr         (run_clr),
        .en          (run_en),
        .count       (t_cur),
        .count_nxt_c (t_nxt)
    );

    for (genvar i = 0; i < NUM_CH; i++) begin : g_lane
        spike_lane #(
            .TIME_W(TIME_W)
        ) u_lane (
            .clk     (clk),
            .rst_n   (rst_n),
            .load    (lane_load),
            .clr     (lane_clr),
            .run     (lane_run),
            .in_time (in_times[i*TIME_W +: TIME_W]),
            .t_now   (t_nxt),
            .spike   (spike[i])
        );
    end

    assign gamma_start = gamma_start_q;
    assign gamma_clear = gamma_clear_q;
    assign busy        = busy_q;
    assign t_now       = t_cur;

endmodule
